i2s_rx_peripheral: RTL

Bus-mapped I2S receiver: the capture-side counterpart to the I2S transmit peripheral. It oversamples external SCK/WS/SD pins on the system clock and deserializes 16-bit left/right samples, Philips I2S format (MSB one SCK after WS edge). Complete stereo frames go into a small FIFO that the processor drains over the same cs/rd/wr/addr/din/dout bus used by the other peripherals. In loopback benches it sits directly downstream of the transmitter's SD/SCK/WS outputs.

---
 rtl/i2s_pkg.sv | 28 ++
 rtl/i2s_rx_fifo.sv | 60 ++++++
 rtl/i2s_rx_peripheral.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: definitions shared by the I2S receive peripheral and its FIFO.
//   - bus register addresses for control, pop, head-left, head-right and status
//   - status register bit positions
//   - receiver FSM state encoding
//   - per-channel sample width
package i2s_pkg;

   localparam int SAMPLE_W = 16;

   localparam logic [3:0] ADDR_CTRL   = 4'h0;
   localparam logic [3:0] ADDR_POP    = 4'h2;
   localparam logic [3:0] ADDR_LEFT   = 4'h4;
   localparam logic [3:0] ADDR_RIGHT  = 4'h6;
   localparam logic [3:0] ADDR_STATUS = 4'h8;

   localparam int STAT_EMPTY    = 0;
   localparam int STAT_FULL     = 1;
   localparam int STAT_OVERRUN  = 2;
   localparam int STAT_SYNC_ERR = 3;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_SYNC     = 2'd1,
      ST_LEFT     = 2'd2,
      ST_RIGHT    = 2'd3
   } rx_state_e;

endpackage

// File: rtl/i2s_rx_fifo.sv
// i2s_rx_fifo: synchronous depth x nBits frame FIFO.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   push, wdata       write request and frame data
//   pop               read-advance request (ignored when empty)
//   rdata             current head entry (meaningless while empty)
//   full, empty       occupancy flags
// A push while full is accepted only when a pop happens in the same cycle.
module i2s_rx_fifo #(
   parameter int nBits = 32,
   parameter int depth = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [nBits-1:0] wdata,
   output logic [nBits-1:0] rdata,
   output logic             full,
   output logic             empty
);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   localparam int PW = $clog2(depth) + 1;

   logic [nBits-1:0] mem_q [depth];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                  (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
   assign rdata = mem_q[rd_ptr_q[PW-2:0]];

   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[PW-2:0]] <= wdata;
   end

endmodule

// File: rtl/i2s_rx_peripheral.sv
// i2s_rx_peripheral: bus-mapped Philips I2S receiver.
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   cs, rd, wr          bus select and strobes
//   addr, din           register address and write data
//   dout                registered read data
//   SCK, WS, SD         external I2S pins, asynchronous to clk
//   irq                 high while enabled and the frame FIFO is non-empty
// Frames are stored as {right, left}; reads of the head are non-destructive.
module i2s_rx_peripheral #(
   parameter int tamPro  = 16,
   parameter int tamAddr = 4,
   parameter int nBits   = 32,
   parameter int depth   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cs,
   input  logic               rd,
   input  logic               wr,
   input  logic [tamAddr-1:0] addr,
   input  logic [tamPro-1:0]  din,
   output logic [tamPro-1:0]  dout,
   input  logic               SCK,
   input  logic               WS,
   input  logic               SD,
   output logic               irq
);

   import i2s_pkg::*;

   logic [2:0]        sck_sync_q, sck_sync_d;
   logic [1:0]        ws_sync_q, ws_sync_d;
   logic [1:0]        sd_sync_q, sd_sync_d;
   rx_state_e         state_q, state_d;
   logic [tamPro-1:0] shift_q, shift_d, shift_next;
   logic [tamPro-1:0] left_q, left_d;
   logic [4:0]        bit_cnt_q, bit_cnt_d, cnt_next;
   logic              ws_prev_q, ws_prev_d;
   logic              enable_q, enable_d;
   logic              overrun_q, overrun_d;
   logic              sync_err_q, sync_err_d;
   logic [tamPro-1:0] dout_q, dout_d;

   logic              sck_rise, ws_now, sd_now, ws_edge, word_ok;
   logic              wr_ctrl, wr_pop, push, set_sync_err;
   logic              fifo_full, fifo_empty;
   logic [nBits-1:0]  fifo_rdata;
   logic              unused_din;

   assign unused_din = ^din[tamPro-1:2];

   assign wr_ctrl = cs && wr && (addr == tamAddr'(ADDR_CTRL));
   assign wr_pop  = cs && wr && (addr == tamAddr'(ADDR_POP)) && din[0];

   // Stage 1/2 resynchronise the pins; stage 3 of SCK is only for edge detect,
   // so WS/SD at stage 2 line up with the detected SCK rise.
   always_comb begin
      sck_sync_d = {sck_sync_q[1:0], SCK};
      ws_sync_d  = {ws_sync_q[0], WS};
      sd_sync_d  = {sd_sync_q[0], SD};
      sck_rise   = sck_sync_q[1] && !sck_sync_q[2];
      ws_now     = ws_sync_q[1];
      sd_now     = sd_sync_q[1];
      shift_next = {shift_q[tamPro-2:0], sd_now};
      cnt_next   = (bit_cnt_q == 5'd31) ? bit_cnt_q : bit_cnt_q + 5'd1;
      ws_edge    = sck_rise && (ws_now != ws_prev_q);
      word_ok    = (cnt_next == 5'(tamPro));
   end

   // A WS change closes the current word; the bit sampled on that edge is
   // its LSB, so the count including it must be exactly one sample width.
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      ws_prev_d    = ws_prev_q;
      left_d       = left_q;
      push         = 1'b0;
      set_sync_err = 1'b0;
      if (sck_rise) begin
         ws_prev_d = ws_now;
         shift_d   = shift_next;
         bit_cnt_d = cnt_next;
      end
      case (state_q)
         ST_DISABLED: state_d = ST_SYNC;
         ST_SYNC: begin
            if (ws_edge) begin
               bit_cnt_d = '0;
               if (ws_prev_q && !ws_now) state_d = ST_LEFT;
            end
         end
         ST_LEFT: begin
            if (ws_edge) begin
               bit_cnt_d = '0;
               if (word_ok) begin
                  left_d  = shift_next;
                  state_d = ST_RIGHT;
               end else begin
                  set_sync_err = 1'b1;
                  state_d      = ST_SYNC;
               end
            end
         end
         ST_RIGHT: begin
            if (ws_edge) begin
               bit_cnt_d = '0;
               if (word_ok) begin
                  push    = 1'b1;
                  state_d = ST_LEFT;
               end else begin
                  set_sync_err = 1'b1;
                  state_d      = ST_SYNC;
               end
            end
         end
         default: state_d = ST_DISABLED;
      endcase
      // Disabling abandons any word in flight but leaves the FIFO intact.
      if (!enable_q) begin
         state_d      = ST_DISABLED;
         shift_d      = '0;
         bit_cnt_d    = '0;
         left_d       = '0;
         push         = 1'b0;
         set_sync_err = 1'b0;
      end
   end

   // Control register and sticky flags; a set in the same cycle as a clear
   // wins because it is applied last. A pop in the push cycle frees a slot.
   always_comb begin
      enable_d   = enable_q;
      overrun_d  = overrun_q;
      sync_err_d = sync_err_q;
      if (wr_ctrl) begin
         enable_d = din[0];
         if (din[1]) begin
            overrun_d  = 1'b0;
            sync_err_d = 1'b0;
         end
      end
      if (push && fifo_full && !wr_pop) overrun_d = 1'b1;
      if (set_sync_err) sync_err_d = 1'b1;
   end

   // Read mux; an empty FIFO reads back as zero rather than stale storage.
   always_comb begin
      dout_d = '0;
      if (cs && rd) begin
         if (addr == tamAddr'(ADDR_LEFT)) begin
            dout_d = fifo_empty ? '0 : fifo_rdata[tamPro-1:0];
         end else if (addr == tamAddr'(ADDR_RIGHT)) begin
            dout_d = fifo_empty ? '0 : fifo_rdata[nBits-1:tamPro];
         end else if (addr == tamAddr'(ADDR_STATUS)) begin
            dout_d[STAT_EMPTY]    = fifo_empty;
            dout_d[STAT_FULL]     = fifo_full;
            dout_d[STAT_OVERRUN]  = overrun_q;
            dout_d[STAT_SYNC_ERR] = sync_err_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_sync_q <= '0;
         ws_sync_q  <= '0;
         sd_sync_q  <= '0;
         state_q    <= ST_DISABLED;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         ws_prev_q  <= 1'b0;
         left_q     <= '0;
         enable_q   <= 1'b0;
         overrun_q  <= 1'b0;
         sync_err_q <= 1'b0;
         dout_q     <= '0;
      end else begin
         sck_sync_q <= sck_sync_d;
         ws_sync_q  <= ws_sync_d;
         sd_sync_q  <= sd_sync_d;
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         ws_prev_q  <= ws_prev_d;
         left_q     <= left_d;
         enable_q   <= enable_d;
         overrun_q  <= overrun_d;
         sync_err_q <= sync_err_d;
         dout_q     <= dout_d;
      end
   end

   i2s_rx_fifo #(
      .nBits (nBits),
      .depth (depth)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (wr_pop),
      .wdata ({shift_next, left_q}),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign dout = dout_q;
   assign irq  = enable_q && !fifo_empty;

endmodule
